char_buf_arbiter: RTL and testbench
===================================

# char_buf_arbiter

Arbiter and sequencer for the single-port character RAM behind the text-mode VGA path. Three requesters share the RAM: the video character fetch (reads, hard real-time), the built-in clear engine (bulk fill), and the host writer (UART command decoder, single writes). The block sits between those requesters and the RAM macro inside the character-buffer subsystem under `common_top`.

## Interface

Parameters:
- `cols`, 80, characters per row
- `rows`, 30, character rows
- `w_char`, 8, character code width
- `w_addr`, `$clog2(cols*rows)`, RAM address width (12 at default)
- `clear_char`, 8'h20, fill value written by the clear engine

Ports:
- `clk`  in  1  system clock (50 MHz on board)
- `rst_n`  in  1  asynchronous, active-low reset
- `vid_req`  in  1  video read request, one cycle per character
- `vid_addr`  in  w_addr  video read address
- `vid_rdata`  out  w_char  read data, valid when `vid_rvalid`
- `vid_rvalid`  out  1  read-data strobe
- `wr_valid`  in  1  host write request
- `wr_addr`  in  w_addr  host write address
- `wr_data`  in  w_char  host write data
- `wr_ready`  out  1  host write accepted this cycle
- `wr_err`  out  1  one-cycle pulse: accepted write was out of range
- `clr_start`  in  1  one-cycle pulse to start a full-screen clear
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse at clear completion
- `ram_en`  out  1  RAM access enable
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  w_addr  RAM address
- `ram_wdata`  out  w_char  RAM write data
- `ram_rdata`  in  w_char  RAM read data, one-cycle latency

## Operation

- Fixed priority: video > clear > host. There is one RAM access per cycle.
- Video: when `vid_req`=1, the access is granted unconditionally in that cycle with `ram_en`=1, `ram_we`=0, and `ram_addr`=`vid_addr`. It never stalls.
- Clear engine FSM has three states:
  - IDLE: `clr_start` moves to CLEAR and resets the counter to 0.
  - CLEAR: each cycle with `vid_req`=0 writes `clear_char` at the counter address and increments the counter. After writing address cols*rows−1, the FSM moves to DONE.
  - DONE: `clr_done`=1 for exactly one cycle, then IDLE.
- `clr_start` is ignored in CLEAR and DONE.
- `clr_busy`=1 in CLEAR and DONE.
- Host: `wr_ready` = `wr_valid` & ~`vid_req` & ~`clr_busy`.
  - The handshake is valid/ready. `wr_addr` and `wr_data` must stay stable while `wr_valid`=1 and `wr_ready`=0.
- Range check: an accepted write with `wr_addr` ≥ cols*rows is consumed (`wr_ready`=1) but suppressed (`ram_en`=`ram_we`=0), and `wr_err` pulses on the next cycle.
- Simultaneous `clr_start` and `wr_valid` in IDLE: the host write is granted in that cycle if video is idle. Clearing begins the following cycle.
- Idle cycles (no grant): `ram_en`=0, and `ram_addr`/`ram_wdata` hold their previous values.

## Timing

- Video read latency: request in cycle N, then `vid_rvalid`=1 and `vid_rdata`=`ram_rdata` in cycle N+1.
  - `vid_rdata` is a pass-through of `ram_rdata`. `vid_rvalid` is the registered `vid_req`.
- RAM control outputs are combinational from the grant decision. `ram_addr`/`ram_wdata` hold registers retain the last driven values.
- Clear duration: cols*rows + (number of video-occupied cycles) cycles in CLEAR, plus 1 cycle in DONE. At defaults with no video traffic: `clr_start` in cycle 0, first write in cycle 1, last write in cycle 2400, `clr_done` in cycle 2401, `clr_busy` low from cycle 2402.
- Reset values: `vid_rvalid`=0, `wr_err`=0, `clr_busy`=0, `clr_done`=0, FSM=IDLE, counter=0, hold registers=0.
- Reset asserted mid-clear aborts immediately. No `clr_done` is produced, and the buffer contents are undefined.
- The counter never wraps past cols*rows−1. The compare is on the exact terminal value, not on a power of two.

## Structure

- Package `char_buf_pkg` holds:
  - `cols`/`rows` defaults, the `w_addr` function, and `clear_char`
  - the clear FSM enum `clr_state_t` {IDLE, CLEAR, DONE}
  - the grant enum `gnt_t` {GNT_NONE, GNT_VID, GNT_CLR, GNT_HOST}
- Sub-module `char_buf_clear_seq` contains the clear FSM and counter. Its inputs are `clr_start` and `stall` (= `vid_req`). Its outputs are `clr_busy`, `clr_done`, `clr_we`, and `clr_addr`.
- The top level contains the priority mux, range check, the `vid_rvalid` register, and the hold registers.

## Test plan

- Video-only: `vid_req` pulsed at addresses 0, 5, 2399 against a RAM model preloaded with 0x41+addr → `vid_rvalid` one cycle after each request, with data matching the model.
- Host write with collision: `wr_valid` at addr 100, data 0x5A, while `vid_req`=1 for 3 cycles → `wr_ready`=0 for 3 cycles, then accepted; RAM[100]=0x5A; video reads unaffected.
- Clear without traffic: `clr_start` → 2400 writes of 0x20; `clr_done` in cycle 2401; `clr_busy` spans cycles 1–2401.
- Clear with video every 16th cycle → the clear completes with every address written exactly once, extended by the number of stolen cycles; the host is held off (`wr_ready`=0) throughout.
- Out-of-range write to addr 2400 → `wr_ready`=1, no `ram_we`, `wr_err` pulse the next cycle.
- `rst_n` low at clear address 1000 → `clr_busy`=0 asynchronously, no `clr_done`; a new `clr_start` then restarts from address 0.

Source files
------------

// File: rtl/char_buf_arbiter_pkg.sv
// Shared types and defaults for the character-buffer RAM arbiter.
package char_buf_pkg;

  localparam int unsigned cols_default       = 80;
  localparam int unsigned rows_default       = 30;
  localparam logic [7:0]  clear_char_default = 8'h20;

  // Address width needed to cover a buffer of the given depth.
  function automatic int unsigned calc_w_addr(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_CLR, GNT_HOST} gnt_t;

endpackage

// File: rtl/char_buf_arbiter_if.sv
// Requester and RAM-side signals of the character-buffer arbiter.
// master: the environment (video, host, clear trigger, RAM macro).
// slave:  the arbiter itself.
interface char_buf_arbiter_if #(
  parameter int unsigned w_addr = 12,
  parameter int unsigned w_char = 8
);
  logic              vid_req;
  logic [w_addr-1:0] vid_addr;
  logic [w_char-1:0] vid_rdata;
  logic              vid_rvalid;

  logic              wr_valid;
  logic [w_addr-1:0] wr_addr;
  logic [w_char-1:0] wr_data;
  logic              wr_ready;
  logic              wr_err;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              ram_en;
  logic              ram_we;
  logic [w_addr-1:0] ram_addr;
  logic [w_char-1:0] ram_wdata;
  logic [w_char-1:0] ram_rdata;

  modport master (
    output vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    input  vid_rdata, vid_rvalid, wr_ready, wr_err, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    output vid_rdata, vid_rvalid, wr_ready, wr_err, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/char_buf_arbiter_clear_seq.sv
// Full-screen clear sequencer: walks every buffer address once, yielding
// to video whenever stall is high.
//
//   state | meaning
//   IDLE  | waiting for clr_start
//   CLEAR | writing fill value at cnt, advancing on non-stalled cycles
//   DONE  | one-cycle completion pulse, then back to IDLE
module char_buf_clear_seq
  import char_buf_pkg::*;
#(
  parameter int unsigned cols   = cols_default,
  parameter int unsigned rows   = rows_default,
  parameter int unsigned w_addr = calc_w_addr(cols * rows)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic              stall,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [w_addr-1:0] clr_addr
);

  // Exact terminal address; the buffer depth is not a power of two.
  localparam logic [w_addr-1:0] last_addr = w_addr'(cols * rows - 1);

  clr_state_t        state;
  logic [w_addr-1:0] cnt;

  // Clear FSM with registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (!stall) begin
            if (cnt == last_addr) begin
              state    <= DONE;
              clr_done <= 1'b1;
            end else begin
              cnt <= cnt + w_addr'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR) && !stall;
  assign clr_addr = cnt;

endmodule

// File: rtl/char_buf_arbiter.sv
// Single-port character RAM arbiter: video > clear > host, one access/cycle.
module char_buf_arbiter
  import char_buf_pkg::*;
#(
  parameter int unsigned       cols       = cols_default,
  parameter int unsigned       rows       = rows_default,
  parameter int unsigned       w_char     = 8,
  parameter int unsigned       w_addr     = calc_w_addr(cols * rows),
  parameter logic [w_char-1:0] clear_char = w_char'(clear_char_default)
) (
  input logic               clk,
  input logic               rst_n,
  char_buf_arbiter_if.slave bus
);

  localparam logic [w_addr:0] depth_ext = (w_addr + 1)'(cols * rows);

  logic              clr_busy;
  logic              clr_done;
  logic              clr_we;
  logic [w_addr-1:0] clr_addr;

  logic              wr_ready;
  logic              wr_in_range;
  gnt_t              gnt;

  logic              ram_en;
  logic              ram_we;
  logic [w_addr-1:0] ram_addr;
  logic [w_char-1:0] ram_wdata;
  logic [w_addr-1:0] addr_q;
  logic [w_char-1:0] wdata_q;

  logic              vid_rvalid_q;
  logic              wr_err_q;

  char_buf_clear_seq #(
    .cols  (cols),
    .rows  (rows),
    .w_addr(w_addr)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_start(bus.clr_start),
    .stall    (bus.vid_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Host is held off whenever video reads or a clear is running (incl. DONE).
  assign wr_ready    = bus.wr_valid && !bus.vid_req && !clr_busy;
  assign wr_in_range = {1'b0, bus.wr_addr} < depth_ext;

  // Fixed-priority grant; an out-of-range host write is consumed without access.
  always_comb begin
    gnt = GNT_NONE;
    if (bus.vid_req)                gnt = GNT_VID;
    else if (clr_we)                gnt = GNT_CLR;
    else if (wr_ready && wr_in_range) gnt = GNT_HOST;
  end

  // RAM drive from the grant; ungranted cycles replay the held address/data.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (gnt)
      GNT_VID: begin
        ram_en   = 1'b1;
        ram_addr = bus.vid_addr;
      end
      GNT_CLR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = clear_char;
      end
      GNT_HOST: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = bus.wr_addr;
        ram_wdata = bus.wr_data;
      end
      default: ;
    endcase
  end

  // Hold registers: remember the last address and write data driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (ram_en) addr_q  <= ram_addr;
      if (ram_we) wdata_q <= ram_wdata;
    end
  end

  // Read strobe follows the request by one cycle; range error pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_rvalid_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      vid_rvalid_q <= bus.vid_req;
      wr_err_q     <= wr_ready && !wr_in_range;
    end
  end

  assign bus.vid_rdata  = bus.ram_rdata;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.wr_err     = wr_err_q;
  assign bus.clr_busy   = clr_busy;
  assign bus.clr_done   = clr_done;
  assign bus.ram_en     = ram_en;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Bench for char_buf_arbiter: RAM model, per-cycle reference model, directed tests.
module tb_char_buf_arbiter;

  localparam int depth = 2400;

  logic clk;
  logic rst_n;

  char_buf_arbiter_if #(.w_addr(12), .w_char(8)) bus ();

  char_buf_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM macro model (one-cycle read latency) with per-address write counters.
  logic [7:0] ram_mem [0:4095];
  logic [7:0] ram_rd_q;
  int         wcnt [0:4095];
  logic       do_preload  = 1'b0;
  logic       do_zero_cnt = 1'b0;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= 8'(8'h41 + i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_addr] <= bus.ram_wdata;
        wcnt[bus.ram_addr]    <= wcnt[bus.ram_addr] + 1;
      end else begin
        ram_rd_q <= ram_mem[bus.ram_addr];
      end
    end
    if (do_zero_cnt) for (int i = 0; i < 4096; i++) wcnt[i] <= 0;
  end

  assign bus.ram_rdata = ram_rd_q;

  // Reference model: shadow contents, clear progress as a plain pointer.
  logic [7:0]  shadow [0:4095];
  int          m_ptr;        // next clear address, -1 when no clear is walking
  bit          m_done;
  bit          m_prev_vid;
  logic [7:0]  m_prev_data;
  bit          m_err;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;

  bit          e_busy, e_clr_wr, e_ready, e_inr, e_en, e_we, e_new_done, e_idle;
  logic [11:0] e_addr;
  logic [7:0]  e_wdata;

  always @(negedge clk) begin
    if (do_preload) for (int i = 0; i < 4096; i++) shadow[i] = 8'(8'h41 + i);
    if (!rst_n) begin
      m_ptr = -1; m_done = 0; m_prev_vid = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_prev_data = '0;
      chk("rst_vid_rvalid", {31'd0, bus.vid_rvalid}, 0);
      chk("rst_wr_err",     {31'd0, bus.wr_err},     0);
      chk("rst_clr_busy",   {31'd0, bus.clr_busy},   0);
      chk("rst_clr_done",   {31'd0, bus.clr_done},   0);
    end else begin
      e_busy = (m_ptr >= 0) || m_done;
      chk("m_clr_busy", {31'd0, bus.clr_busy}, {31'd0, e_busy});
      chk("m_clr_done", {31'd0, bus.clr_done}, {31'd0, m_done});
      chk("m_vid_rvalid", {31'd0, bus.vid_rvalid}, {31'd0, m_prev_vid});
      if (m_prev_vid) chk("m_vid_rdata", {24'd0, bus.vid_rdata}, {24'd0, m_prev_data});
      chk("m_wr_err", {31'd0, bus.wr_err}, {31'd0, m_err});

      e_clr_wr = (m_ptr >= 0) && !bus.vid_req;
      e_ready  = bus.wr_valid && !bus.vid_req && !e_busy;
      e_inr    = int'(bus.wr_addr) < depth;
      e_en = 0; e_we = 0; e_addr = m_addr; e_wdata = m_wdata;
      if (bus.vid_req) begin
        e_en = 1; e_addr = bus.vid_addr;
      end else if (e_clr_wr) begin
        e_en = 1; e_we = 1; e_addr = 12'(m_ptr); e_wdata = 8'h20;
      end else if (e_ready && e_inr) begin
        e_en = 1; e_we = 1; e_addr = bus.wr_addr; e_wdata = bus.wr_data;
      end
      chk("m_wr_ready", {31'd0, bus.wr_ready}, {31'd0, e_ready});
      chk("m_ram_en",   {31'd0, bus.ram_en},   {31'd0, e_en});
      chk("m_ram_we",   {31'd0, bus.ram_we},   {31'd0, e_we});
      chk("m_ram_addr", {20'd0, bus.ram_addr}, {20'd0, e_addr});
      if (e_we || !e_en) chk("m_ram_wdata", {24'd0, bus.ram_wdata}, {24'd0, e_wdata});

      m_prev_vid  = bus.vid_req;
      m_prev_data = shadow[bus.vid_addr];
      if (e_we) shadow[e_addr] = e_wdata;
      if (e_en) m_addr = e_addr;
      if (e_we) m_wdata = e_wdata;
      m_err = e_ready && !e_inr;

      e_idle     = (m_ptr < 0) && !m_done;
      e_new_done = e_clr_wr && (m_ptr == depth - 1);
      if (e_idle && bus.clr_start) m_ptr = 0;
      else if (e_clr_wr) m_ptr = (m_ptr == depth - 1) ? -1 : m_ptr + 1;
      m_done = e_new_done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int k;
  int seen_ready;
  int bad;

  initial begin
    rst_n = 1'b1;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_start = 0;
    #2 rst_n = 1'b0;
    do_preload = 1; do_zero_cnt = 1;
    repeat (3) @(posedge clk);
    #1;
    do_preload = 0; do_zero_cnt = 0;
    rst_n = 1'b1;
    cyc();

    // Video-only reads against preloaded 0x41+addr.
    bus.vid_req = 1; bus.vid_addr = 12'd0;
    cyc();
    bus.vid_req = 0;
    chk("vid0_rvalid", {31'd0, bus.vid_rvalid}, 1);
    chk("vid0_data", {24'd0, bus.vid_rdata}, 32'h41);
    cyc();
    chk("vid_rvalid_drop", {31'd0, bus.vid_rvalid}, 0);
    bus.vid_req = 1; bus.vid_addr = 12'd5;
    cyc();
    bus.vid_addr = 12'd2399;
    chk("vid5_data", {24'd0, bus.vid_rdata}, 32'h46);
    cyc();
    bus.vid_req = 0;
    chk("vid2399_data", {24'd0, bus.vid_rdata}, 32'hA0);
    cyc();

    // Host write colliding with 3 video cycles.
    bus.wr_valid = 1; bus.wr_addr = 12'd100; bus.wr_data = 8'h5A;
    bus.vid_req = 1;
    for (int i = 0; i < 3; i++) begin
      bus.vid_addr = 12'(7 + i);
      #1;
      chk("coll_ready_low", {31'd0, bus.wr_ready}, 0);
      if (i > 0) chk("coll_vid_data", {24'd0, bus.vid_rdata}, 32'(8'(8'h41 + 7 + i - 1)));
      cyc();
    end
    bus.vid_req = 0;
    #1;
    chk("coll_ready_high", {31'd0, bus.wr_ready}, 1);
    chk("coll_ram_addr", {20'd0, bus.ram_addr}, 100);
    cyc();
    bus.wr_valid = 0;
    chk("coll_last_vid", {24'd0, bus.vid_rdata}, 32'h4A);
    cyc();
    chk("coll_mem100", {24'd0, ram_mem[100]}, 32'h5A);

    // Out-of-range write: consumed, no access, error pulse next cycle.
    bus.wr_valid = 1; bus.wr_addr = 12'd2400; bus.wr_data = 8'h11;
    #1;
    chk("oor_ready", {31'd0, bus.wr_ready}, 1);
    chk("oor_ram_en", {31'd0, bus.ram_en}, 0);
    chk("oor_ram_we", {31'd0, bus.ram_we}, 0);
    cyc();
    bus.wr_valid = 0;
    chk("oor_err_pulse", {31'd0, bus.wr_err}, 1);
    cyc();
    chk("oor_err_clear", {31'd0, bus.wr_err}, 0);

    // Clear without traffic; host write in the same cycle as clr_start wins.
    do_zero_cnt = 1;
    cyc();
    do_zero_cnt = 0;
    bus.clr_start = 1; bus.wr_valid = 1; bus.wr_addr = 12'd50; bus.wr_data = 8'h33;
    #1;
    chk("start_host_ready", {31'd0, bus.wr_ready}, 1);
    chk("start_host_addr", {20'd0, bus.ram_addr}, 50);
    cyc();
    bus.clr_start = 0; bus.wr_valid = 0;
    k = 1;
    chk("clr1_busy_c1", {31'd0, bus.clr_busy}, 1);
    chk("clr1_first_addr", {20'd0, bus.ram_addr}, 0);
    while (!bus.clr_done && k < 3000) begin
      cyc();
      k++;
    end
    chk("clr1_done_cycle", k, 2401);
    bad = 0;
    for (int i = 0; i < depth; i++) begin
      if (wcnt[i] != ((i == 50) ? 2 : 1)) bad++;
      if (ram_mem[i] !== 8'h20) bad++;
    end
    chk("clr1_bad_cells", bad, 0);
    cyc();
    chk("clr1_busy_after", {31'd0, bus.clr_busy}, 0);

    // Clear with video every 16th cycle and a pending host write.
    do_zero_cnt = 1;
    cyc();
    do_zero_cnt = 0;
    bus.clr_start = 1;
    cyc();
    bus.clr_start = 0;
    bus.wr_valid = 1; bus.wr_addr = 12'd300; bus.wr_data = 8'h77;
    k = 1; seen_ready = 0;
    while (k < 4000) begin
      bus.vid_req  = (k % 16 == 0);
      bus.vid_addr = 12'(k % depth);
      #1;
      if (bus.wr_ready) seen_ready++;
      if (bus.clr_done) break;
      cyc();
      k++;
    end
    chk("clr2_done_cycle", k, 2560);
    chk("clr2_host_held", seen_ready, 0);
    bad = 0;
    for (int i = 0; i < depth; i++) if (wcnt[i] != 1) bad++;
    chk("clr2_once_each", bad, 0);
    bus.vid_req = 0;
    cyc();
    chk("clr2_host_after", {31'd0, bus.wr_ready}, 1);
    cyc();
    bus.wr_valid = 0;
    chk("clr2_mem300", {24'd0, ram_mem[300]}, 32'h77);

    // Reset in the middle of a clear, then restart from address 0.
    bus.clr_start = 1;
    cyc();
    bus.clr_start = 0;
    k = 1;
    while (!(bus.ram_we && bus.ram_addr == 12'd1000) && k < 3000) begin
      cyc();
      k++;
    end
    chk("abort_reach_1000", k, 1001);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_async", {31'd0, bus.clr_busy}, 0);
    chk("abort_no_done", {31'd0, bus.clr_done}, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("abort_still_idle", {31'd0, bus.clr_busy}, 0);
    bus.clr_start = 1;
    cyc();
    bus.clr_start = 0;
    k = 1;
    chk("restart_addr0", {20'd0, bus.ram_addr}, 0);
    chk("restart_we", {31'd0, bus.ram_we}, 1);
    while (!bus.clr_done && k < 3000) begin
      cyc();
      k++;
    end
    chk("restart_done_cycle", k, 2401);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
